// File: rtl/ga_eval_pkg.sv
// ga_eval_pkg: shared sizes, evaluator state encoding and packed-word selectors.
package ga_eval_pkg;
    localparam int MAX_SEQ = 16;
    localparam int N_OUT   = 8;
    localparam int WORD_W  = 32;
    localparam int IDX_W   = $clog2(MAX_SEQ);
    localparam int CNT_W   = IDX_W + 1;

    typedef enum logic [2:0] {IDLE, APPLY, SAMPLE, DONE, RELEASE} state_t;

    function automatic logic [WORD_W-1:0] word_sel(input logic [MAX_SEQ*WORD_W-1:0] v,
                                                   input logic [IDX_W-1:0] i);
        return v[i*WORD_W +: WORD_W];
    endfunction

    function automatic logic [N_OUT-1:0] bits_sel(input logic [MAX_SEQ*WORD_W-1:0] v,
                                                  input logic [IDX_W-1:0] i);
        return v[i*WORD_W +: N_OUT];
    endfunction
endpackage

// File: rtl/error_accumulator.sv
// error_accumulator: N_OUT saturating mismatch counters, cleared at run start.
module error_accumulator
    import ga_eval_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    enable,
    input  logic [N_OUT-1:0]        mismatch,
    output logic [N_OUT*WORD_W-1:0] sums
);
    logic [N_OUT-1:0][WORD_W-1:0] sum_q;

    assign sums = sum_q;

    always_ff @(posedge clk) begin
        if (reset || clear)
            sum_q <= '0;
        else if (enable)
            for (int k = 0; k < N_OUT; k++)
                if (mismatch[k] && !(&sum_q[k]))
                    sum_q[k] <= sum_q[k] + 1'b1;
    end
endmodule

// File: rtl/chrom_fitness_evaluator.sv
// chrom_fitness_evaluator: drives the candidate circuit with each test vector,
// scores masked output mismatches, and runs the start/done/feedback handshake.
module chrom_fitness_evaluator
    import ga_eval_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start_processing_chrom,
    input  logic                     done_processing_feedback,
    input  logic [WORD_W-1:0]        sequences_to_process,
    input  logic [MAX_SEQ*WORD_W-1:0] input_sequence,
    input  logic [MAX_SEQ*WORD_W-1:0] expected_output,
    input  logic [MAX_SEQ*WORD_W-1:0] valid_output,
    input  logic [N_OUT-1:0]         circuit_out,
    output logic [WORD_W-1:0]        circuit_in,
    output logic                     ready_to_process,
    output logic                     done_processing_chrom,
    output logic [N_OUT*WORD_W-1:0]  error_sum
);
    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [7:0]       settle;
    logic [CNT_W-1:0] n;
    logic             last;
    logic [N_OUT-1:0] mismatch;

    assign n = (sequences_to_process > WORD_W'(MAX_SEQ)) ? CNT_W'(MAX_SEQ)
                                                          : sequences_to_process[CNT_W-1:0];
    assign last     = ({1'b0, idx} == n - 1'b1);
    assign mismatch = (circuit_out ^ bits_sel(expected_output, idx)) & bits_sel(valid_output, idx);

    assign ready_to_process      = (state == IDLE);
    assign done_processing_chrom = (state == DONE);

    error_accumulator u_acc (
        .clk      (clk),
        .reset    (reset),
        .clear    (state == IDLE && start_processing_chrom),
        .enable   (state == SAMPLE),
        .mismatch (mismatch),
        .sums     (error_sum)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            settle     <= '0;
            circuit_in <= '0;
        end else begin
            case (state)
                IDLE: if (start_processing_chrom) begin
                    idx    <= '0;
                    settle <= '0;
                    if (n == '0) begin
                        state <= DONE;
                    end else begin
                        circuit_in <= word_sel(input_sequence, '0);
                        state      <= APPLY;
                    end
                end
                APPLY: if (settle == 8'(SETTLE_CYCLES - 1)) begin
                    settle <= '0;
                    state  <= SAMPLE;
                end else begin
                    settle <= settle + 1'b1;
                end
                SAMPLE: if (last) begin
                    state <= DONE;
                end else begin
                    idx        <= idx + 1'b1;
                    circuit_in <= word_sel(input_sequence, idx + 1'b1);
                    state      <= APPLY;
                end
                DONE: if (done_processing_feedback) state <= RELEASE;
                // a start still held from the finished run must drop before re-arming
                RELEASE: if (!start_processing_chrom && !done_processing_feedback) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_chrom_fitness_evaluator.sv
// tb_chrom_fitness_evaluator: directed checks of scoring, timing, clamping,
// handshake, mid-run reset and counter saturation.
module tb_chrom_fitness_evaluator;
    import ga_eval_pkg::*;

    logic                      clk = 0;
    logic                      reset = 1;
    logic                      start = 0;
    logic                      feedback = 0;
    logic [WORD_W-1:0]         stp = 0;
    logic [MAX_SEQ*WORD_W-1:0] input_sequence = '0;
    logic [MAX_SEQ*WORD_W-1:0] expected_output = '0;
    logic [MAX_SEQ*WORD_W-1:0] valid_output = '0;
    logic [N_OUT-1:0]          circuit_out;
    logic [WORD_W-1:0]         circuit_in;
    logic                      ready, done;
    logic [N_OUT*WORD_W-1:0]   error_sum;

    int vectors = 0;
    int miscompares = 0;
    int mode = 0;
    logic [WORD_W-1:0] seq [MAX_SEQ];
    logic [WORD_W-1:0] samp_log [64];
    int samp_n = 0;

    chrom_fitness_evaluator #(.SETTLE_CYCLES(4)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .start_processing_chrom   (start),
        .done_processing_feedback (feedback),
        .sequences_to_process     (stp),
        .input_sequence           (input_sequence),
        .expected_output          (expected_output),
        .valid_output             (valid_output),
        .circuit_out              (circuit_out),
        .circuit_in               (circuit_in),
        .ready_to_process         (ready),
        .done_processing_chrom    (done),
        .error_sum                (error_sum)
    );

    always #5 clk = ~clk;

    always_comb circuit_out = (mode == 0) ? circuit_in[7:0] :
                              (mode == 1) ? ~circuit_in[7:0] : circuit_in[7:0] ^ 8'h01;

    always @(negedge clk)
        if (dut.state == SAMPLE && samp_n < 64) begin
            samp_log[samp_n] = circuit_in;
            samp_n++;
        end

    task automatic chk(input string tag, input logic [WORD_W-1:0] obs, input logic [WORD_W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_sums(input string tag, input logic [WORD_W-1:0] e [N_OUT]);
        for (int k = 0; k < N_OUT; k++)
            chk($sformatf("%s_sum%0d", tag, k), error_sum[k*WORD_W +: WORD_W], e[k]);
    endtask

    task automatic set_valid(input logic [7:0] v0, input logic [7:0] vrest);
        for (int i = 0; i < MAX_SEQ; i++)
            valid_output[i*WORD_W +: WORD_W] = {24'h0, (i == 0) ? v0 : vrest};
    endtask

    task automatic wait_done(input string tag, input int exp_cyc);
        int cyc = 0;
        forever begin
            @(negedge clk);
            if (done || cyc >= 200) break;
            @(posedge clk);
            cyc++;
        end
        chk(tag, cyc, exp_cyc);
    endtask

    task automatic go(input string tag, input int exp_cyc);
        start = 1;
        @(posedge clk);
        wait_done(tag, exp_cyc);
    endtask

    task automatic finish_handshake();
        feedback = 1;
        @(negedge clk);
        feedback = 0;
        start = 0;
        @(negedge clk);
        chk("back_to_idle", ready, 1);
    endtask

    initial begin
        logic [WORD_W-1:0] zero8 [N_OUT] = '{default: 0};
        logic [WORD_W-1:0] mask8 [N_OUT] = '{2, 1, 1, 1, 0, 0, 0, 0};
        logic [WORD_W-1:0] two8  [N_OUT] = '{default: 2};
        logic [WORD_W-1:0] sat8  [N_OUT] = '{32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0};
        int s0;
        int found;
        for (int i = 0; i < MAX_SEQ; i++) begin
            seq[i] = 32'hA500_0000 + i * 32'h0001_0100 + 32'(i * 17 + 5);
            input_sequence[i*WORD_W +: WORD_W]  = seq[i];
            expected_output[i*WORD_W +: WORD_W] = seq[i];
        end
        repeat (2) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_cin", circuit_in, 0);
        chk_sums("rst", zero8);
        reset = 0;
        @(negedge clk);

        // perfect match, latency n*(SETTLE+1)
        mode = 0; set_valid(8'hFF, 8'hFF); stp = 3;
        go("match_latency", 15);
        chk_sums("match", zero8);
        chk("match_cin_hold", circuit_in, seq[2]);

        // handshake with start still held
        feedback = 1;
        @(negedge clk);
        chk("fb_done_drop", done, 0);
        chk("fb_not_ready", ready, 0);
        feedback = 0;
        repeat (3) @(negedge clk);
        chk("held_start_ready", ready, 0);
        chk("held_start_done", done, 0);
        start = 0;
        @(negedge clk);
        chk("release_ready", ready, 1);
        repeat (3) @(negedge clk);
        chk("no_rerun_ready", ready, 1);
        chk("no_rerun_cin", circuit_in, seq[2]);

        // masked mismatch
        mode = 1; set_valid(8'h0F, 8'h01); stp = 2;
        go("mask_latency", 10);
        chk_sums("mask", mask8);
        finish_handshake();

        // zero sequences: immediate done, sums cleared
        stp = 0;
        go("zero_latency", 0);
        chk_sums("zero", zero8);
        finish_handshake();

        // clamp 40 -> 16
        mode = 0; set_valid(8'hFF, 8'hFF); stp = 40;
        s0 = samp_n;
        go("clamp_latency", 80);
        chk("clamp_samples", samp_n - s0, 16);
        for (int j = 0; j < MAX_SEQ; j++)
            chk($sformatf("clamp_cin%0d", j), samp_log[(s0 + j) % 64], seq[j]);
        chk_sums("clamp", zero8);
        finish_handshake();

        // reset during SAMPLE of sequence 5
        mode = 1; stp = 8;
        start = 1;
        found = 0;
        for (int c = 0; c < 100 && found == 0; c++) begin
            @(negedge clk);
            if (dut.state == SAMPLE && dut.idx == 4'd5) found = 1;
        end
        chk("reset_reached", found, 1);
        reset = 1;
        @(negedge clk);
        chk("midrst_ready", ready, 1);
        chk("midrst_done", done, 0);
        chk("midrst_cin", circuit_in, 0);
        chk_sums("midrst", zero8);
        reset = 0; start = 0;
        @(negedge clk);
        stp = 2;
        go("fresh_latency", 10);
        chk_sums("fresh", two8);
        finish_handshake();

        // saturation from a preloaded near-full counter
        mode = 2; set_valid(8'h01, 8'h01); stp = 3;
        start = 1;
        @(posedge clk);
        @(negedge clk);
        force dut.u_acc.sum_q = {{(N_OUT-1)*WORD_W{1'b0}}, 32'hFFFF_FFFE};
        @(negedge clk);
        release dut.u_acc.sum_q;
        wait_done("sat_latency", 13);
        chk_sums("sat", sat8);
        finish_handshake();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/chrom_fitness_evaluator.md
Name: chrom_fitness_evaluator

Overview:
Fabric-side stage that consumes the HPS system's evaluation handshake and test-vector exports. It drives the candidate genetic circuit (configured by the chromosome segments) with each input sequence, waits for the circuit outputs to settle, and compares the outputs against the expected values under the valid mask. It accumulates per-output mismatch counts into the error sums returned to the HPS. It also produces the ready/done signals of the start/done/feedback handshake.

Parameters:
MAX_SEQ, 16, number of sequence/expected/valid words supplied by the HPS.
N_OUT, 8, circuit output bits scored; one error sum per bit.
WORD_W, 32, width of every PIO word and error sum.
SETTLE_CYCLES, 4, cycles circuit_in is held before sampling; legal range 1..255.

Ports:
clk  in  1  system clock (single domain).
reset  in  1  synchronous, active-high reset.
start_processing_chrom  in  1  level from HPS: evaluate the currently loaded chromosome.
done_processing_feedback  in  1  HPS acknowledge of done.
sequences_to_process  in  WORD_W  number of sequences to run.
input_sequence  in  MAX_SEQ*WORD_W  packed; word i occupies bits [i*WORD_W +: WORD_W].
expected_output  in  MAX_SEQ*WORD_W  packed; bits [N_OUT-1:0] of each word are used.
valid_output  in  MAX_SEQ*WORD_W  packed mask; bits [N_OUT-1:0] of each word are used.
circuit_out  in  N_OUT  combinational outputs of the circuit under evaluation.
circuit_in  out  WORD_W  stimulus to the circuit.
ready_to_process  out  1  high only in IDLE.
done_processing_chrom  out  1  high in DONE.
error_sum  out  N_OUT*WORD_W  packed mismatch counts; sum k occupies [k*WORD_W +: WORD_W].

Behaviour:
- All outputs are registered or are state decodes. Reset values: state IDLE, ready_to_process=1, done=0, circuit_in=0, all error_sum=0, idx=0, settle counter=0.
- Reset takes effect at any state, including mid-run: the run is aborted and no done is issued.
- n = min(sequences_to_process, MAX_SEQ). Values above MAX_SEQ clamp to MAX_SEQ.
- IDLE: on the edge e0 where start is sampled 1:
  - clear all error_sum registers and set idx=0;
  - if n==0, go to DONE;
  - otherwise load circuit_in=input_sequence[0] and go to APPLY.
- APPLY: hold circuit_in for SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE: for each k, error_sum[k] += (circuit_out[k] ^ expected[idx][k]) & valid[idx][k].
  - Each addition saturates at 2^WORD_W-1.
  - If idx==n-1, go to DONE. Otherwise increment idx, load circuit_in=input_sequence[idx+1], and go to APPLY.
- Timing: done rises at edge e0 + n*(SETTLE_CYCLES+1). The error sums are final on that same edge.
- DONE: done=1 and circuit_in holds its last value.
  - When feedback is sampled 1, go to RELEASE with done=0.
- RELEASE: wait until start==0 and feedback==0, then go to IDLE. A start that is still held therefore never retriggers a run.
- start deasserting during APPLY/SAMPLE is ignored; the run completes.
- Test-vector inputs are read live at load/sample time. The HPS must not change them while ready_to_process=0.
- error_sum holds its value from DONE until the next accepted start.

Decomposition:
- Package ga_eval_pkg: MAX_SEQ, N_OUT, WORD_W, the state enum (IDLE, APPLY, SAMPLE, DONE, RELEASE), and word-select helper functions for the packed vectors.
- One sub-module, error_accumulator. It holds N_OUT saturating WORD_W counters and has clear, enable, a mismatch vector, and the sums as its interface.

Test Plan:
- Perfect match: n=3, SETTLE_CYCLES=4, circuit model out=seq[7:0], expected=seq, valid=0xFF -> all sums 0; done rises exactly 15 cycles after start is sampled.
- Masked mismatch: n=2, circuit out inverted, valid[0]=0x0F, valid[1]=0x01 -> sums[0]=2, sums[1..3]=1, sums[4..7]=0.
- Zero/clamp: sequences_to_process=0 -> done at e0 with sums 0. sequences_to_process=40 -> exactly 16 SAMPLE cycles, and circuit_in steps through seq[0..15] in order.
- Handshake: hold start=1 through done and feedback; assert feedback -> done drops the next cycle; the block stays in RELEASE until both start and feedback are low, then ready=1 and no second run occurs.
- Reset mid-run: assert reset during SAMPLE of sequence 5 -> the next cycle shows ready=1, done=0, circuit_in=0, sums 0; a fresh start then runs correctly.
- Saturation: preload the counter via force to 2^32-2 with 3 mismatches -> sum ends at 0xFFFFFFFF.
